leiwand_rv32_uart: RTL and testbench
====================================

Name: leiwand_rv32_uart

Overview:
Memory-mapped UART peripheral on the core's valid/ready memory bus, next to the internal ROM. The SoC address decoder qualifies `valid` for the window BASE_ADDR..BASE_ADDR+0x1F. The block consumes core loads and stores and drives `rdata`/`ready` back through the SoC read mux. It provides a byte TX FIFO, a byte RX FIFO, and 8N1 serial framing with a programmable divider. This is the console and success channel for the riscv test binaries.

Parameters:
BASE_ADDR, 32'h10013000, base of register window; used only for the address-decode helper constant.
FIFO_DEPTH, 8, entries per TX/RX FIFO; power of two, at least 2.
DIV_RESET, 16'd433, reset value of the divider register.

Ports:
clk      in   1   system clock
reset    in   1   asynchronous, active-low reset
valid    in   1   bus request, already address-qualified
ready    out  1   one-cycle completion pulse
wen      in   4   byte write enables; 0 means read
addr     in   32  byte address; only addr[4:2] decoded
wdata    in   32  write data
rdata    out  32  read data, valid while ready=1
uart_tx  out  1   serial out, idles high
uart_rx  in   1   serial in, asynchronous to clk

Behaviour:
- Reset state: ready=0, rdata=0, uart_tx=1, both FIFOs empty, txen=0, rxen=0, div=DIV_RESET, TX and RX FSMs IDLE.
- Handshake:
  - When valid=1 and ready=0 on a clock edge, ready=1 on the next cycle for exactly one cycle. rdata is registered in that same cycle.
  - The core holds valid until it sees ready.
  - FIFO push/pop side effects occur once per access, at the edge that raises ready.
- Register map (word offset addr[4:2]):
  - 0 txdata. Read: {full,31'b0}. Write with wen[0]=1 pushes wdata[7:0]. A write while full is silently dropped.
  - 1 rxdata. Read: {empty,23'b0,byte}. Pops if non-empty; if empty, byte field is 0. Writes ignored.
  - 2 txctrl. bit0 txen, R/W.
  - 3 rxctrl. bit0 rxen, R/W.
  - 6 div. bits[15:0], R/W. Writes honour wen[1:0] per byte.
  - Other offsets read 0; writes to them are ignored.
- Bit timing: a baud counter reloads to div and counts down. One bit period = div+1 clocks.
- TX FSM: IDLE→START→DATA→STOP→IDLE.
  - Leaves IDLE only when txen=1 and the TX FIFO is non-empty; pops the byte on that edge.
  - START drives 0. DATA shifts 8 bits LSB first. STOP drives 1 for one bit period.
  - Clearing txen mid-frame finishes the current frame.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - FSM IDLE→START→DATA→STOP.
  - IDLE with rxen=1: a synchronized falling edge loads a half-bit count ((div+1)>>1).
  - START: re-samples at mid-bit; if the sample is 1, treat as a glitch and return to IDLE.
  - DATA: samples 8 bits at mid-bit, LSB first.
  - STOP: if the stop sample is 1, push the byte. Stop=0 is a framing error; the byte is dropped.
  - RX FIFO full at push: overrun, the new byte is dropped and old contents are kept.
- Simultaneous events:
  - CPU push on full TX FIFO coinciding with a TX pop: the push succeeds (space computed after pop).
  - Same rule for RX pop and push in the same cycle.
  - Count and pointer width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- div write mid-frame takes effect at the next baud-counter reload.
- Reset assertion mid-frame: immediate return to the reset state; uart_tx=1 asynchronously.

Optional Feature:
LEIWAND_UART_IRQ_EN
- Defined:
  - Adds output `irq` (1 bit, reset 0, registered).
  - Adds offset 4 `ie`: bit0 txwm, bit1 rxwm, R/W.
  - Adds offset 5 `ip`: read-only, bit0 = TX count < 1, bit1 = RX count > 0.
  - irq = |(ie & ip), registered one cycle after the condition.
- Undefined: no irq port. Offsets 4 and 5 read 0 and ignore writes.

Decomposition:
- Shared constants file leiwand_rv32_uart_constants.v holds:
  - register offsets UART_REG_TXDATA..UART_REG_DIV
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3
  - the default base address
- Sub-module leiwand_rv32_uart_fifo (parameter DEPTH, WIDTH=8): push, pop, full, empty, count, dout. Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset: release reset, read offset 0, 1 and 6 → rdata 0x00000000, 0x80000000, 0x000001B1; uart_tx=1.
- TX frame: div=3, txen=1, write 0x55 to txdata → uart_tx shows start 0, then 1,0,1,0,1,0,1,0, then stop 1. Each bit is 4 clocks; frame is 40 clocks.
- TX full: txen=0, write 9 bytes with FIFO_DEPTH=8 → txdata read = 0x80000000. Set txen=1 → exactly 8 bytes transmitted; 9th byte absent.
- RX receive: div=7, rxen=1, drive 8N1 byte 0xA3 on uart_rx → rxdata read 0x000000A3, then next read 0x80000000.
- RX errors: send a frame with stop=0 → rxdata empty. Send 9 valid bytes without reading → first 8 retained in order.
- Handshake and reset: hold valid for 5 cycles → ready high exactly one cycle and one pop only. Assert reset mid-TX-frame → uart_tx=1 immediately and FIFOs empty.

Source files
------------

// File: rtl/leiwand_rv32_uart_pkg.sv
// leiwand_rv32_uart_pkg
// Shared constants for the UART slice: the default register window base,
// word offsets of the register map (addr[4:2]) and the state encoding used
// by both the TX and RX sequencers.
package leiwand_rv32_uart_pkg;

    localparam logic [31:0] UART_BASE_ADDR = 32'h1001_3000;

    localparam logic [2:0] UART_REG_TXDATA = 3'd0;
    localparam logic [2:0] UART_REG_RXDATA = 3'd1;
    localparam logic [2:0] UART_REG_TXCTRL = 3'd2;
    localparam logic [2:0] UART_REG_RXCTRL = 3'd3;
    localparam logic [2:0] UART_REG_IE     = 3'd4;
    localparam logic [2:0] UART_REG_IP     = 3'd5;
    localparam logic [2:0] UART_REG_DIV    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/leiwand_rv32_uart_if.sv
// leiwand_rv32_uart_if
// Core-side valid/ready memory bus as seen by the UART window.
//   valid  request, already address-qualified by the SoC decoder
//   ready  one-cycle completion pulse
//   wen    byte write enables, 0 = read
//   addr   byte address
//   wdata  write data
//   rdata  read data, valid while ready=1
interface leiwand_rv32_uart_if;
    import leiwand_rv32_uart_pkg::*;

    logic        valid;
    logic        ready;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wen, addr, wdata, input  ready, rdata);
    modport slave  (input  valid, wen, addr, wdata, output ready, rdata);

endinterface

// File: rtl/leiwand_rv32_uart_fifo.sv
// leiwand_rv32_uart_fifo
// Synchronous FIFO with show-ahead output (dout is the head entry).
//   clk, rst_n  clock, async active-low reset
//   push, din   write request/data; accepted if not full, or if a pop
//               happens in the same cycle
//   pop         read request; ignored while empty
//   full, empty, count, dout  status and head data
module leiwand_rv32_uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty; index wraps mod DEPTH.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + CW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/leiwand_rv32_uart.sv
// leiwand_rv32_uart
// Memory-mapped 8N1 UART with byte TX/RX FIFOs and a programmable divider
// (bit period = div+1 clocks).
//   clk, reset  system clock, async active-low reset
//   bus         valid/ready slave port (leiwand_rv32_uart_if.slave)
//   irq         interrupt, only when LEIWAND_UART_IRQ_EN is defined
//   uart_tx     serial out, idles high
//   uart_rx     serial in, asynchronous to clk
//
// state  | meaning
// IDLE   | line idle; TX waits for txen+data, RX waits for falling edge
// START  | start bit (TX drives 0, RX re-checks at mid-bit)
// DATA   | 8 data bits, LSB first
// STOP   | stop bit (TX drives 1, RX pushes byte if stop sample is 1)
module leiwand_rv32_uart
    import leiwand_rv32_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = UART_BASE_ADDR,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic               clk,
    input  logic               reset,
    leiwand_rv32_uart_if.slave bus,
`ifdef LEIWAND_UART_IRQ_EN
    output logic               irq,
`endif
    output logic               uart_tx,
    input  logic               uart_rx
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] WINDOW_LAST = BASE_ADDR + 32'h1F;

    logic        held, access, wr, rd;
    logic [2:0]  off;
    logic [31:0] rd_val;
    logic        txen, rxen;
    logic [15:0] div;
    logic [16:0] div_inc;

    logic          tx_full, tx_empty, tx_pop, tx_push;
    logic [7:0]    tx_dout;
    logic [CW-1:0] tx_count;
    logic          rx_full, rx_empty, rx_pop, rx_push;
    logic [7:0]    rx_dout;
    logic [CW-1:0] rx_count;

    uart_state_e tx_state, tx_state_d, rx_state, rx_state_d;
    logic [15:0] tx_baud, rx_baud;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift;
    logic        tx_tick, rx_tick;
    logic        rx_s1, rx_s2, rx_s3, rx_fall;

`ifdef LEIWAND_UART_IRQ_EN
    logic [1:0] ie, ip;
    assign ip = {rx_count != '0, tx_count == '0};
`endif

    // A request still held after its ready pulse is the same transaction;
    // the next one is accepted only after valid has dropped.
    assign access  = bus.valid && !held;
    assign wr      = access && (bus.wen != 4'b0);
    assign rd      = access && (bus.wen == 4'b0);
    assign off     = bus.addr[4:2];
    assign tx_push = wr && (off == UART_REG_TXDATA) && bus.wen[0];
    assign rx_pop  = rd && (off == UART_REG_RXDATA);
    assign div_inc = {1'b0, div} + 17'd1;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0], bus.wdata[31:16], bus.wen[3:2],
                           WINDOW_LAST, tx_count, rx_count, rx_full, div_inc[0]};

    leiwand_rv32_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .rst_n(reset), .push(tx_push), .din(bus.wdata[7:0]), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .count(tx_count), .dout(tx_dout));

    leiwand_rv32_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .rst_n(reset), .push(rx_push), .din(rx_shift), .pop(rx_pop),
        .full(rx_full), .empty(rx_empty), .count(rx_count), .dout(rx_dout));

    always_comb begin
        rd_val = 32'b0;
        case (off)
            UART_REG_TXDATA: rd_val = {tx_full, 31'b0};
            UART_REG_RXDATA: rd_val = {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_dout};
            UART_REG_TXCTRL: rd_val = {31'b0, txen};
            UART_REG_RXCTRL: rd_val = {31'b0, rxen};
            UART_REG_DIV:    rd_val = {16'b0, div};
`ifdef LEIWAND_UART_IRQ_EN
            UART_REG_IE:     rd_val = {30'b0, ie};
            UART_REG_IP:     rd_val = {30'b0, ip};
`endif
            default:         rd_val = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held      <= 1'b0;
            bus.ready <= 1'b0;
            bus.rdata <= 32'b0;
            txen      <= 1'b0;
            rxen      <= 1'b0;
            div       <= DIV_RESET;
`ifdef LEIWAND_UART_IRQ_EN
            ie        <= 2'b0;
            irq       <= 1'b0;
`endif
        end else begin
            bus.ready <= access;
            if (!bus.valid)  held <= 1'b0;
            else if (access) held <= 1'b1;
            if (access) bus.rdata <= rd_val;
            if (wr) begin
                case (off)
                    UART_REG_TXCTRL: if (bus.wen[0]) txen <= bus.wdata[0];
                    UART_REG_RXCTRL: if (bus.wen[0]) rxen <= bus.wdata[0];
                    UART_REG_DIV: begin
                        if (bus.wen[0]) div[7:0]  <= bus.wdata[7:0];
                        if (bus.wen[1]) div[15:8] <= bus.wdata[15:8];
                    end
`ifdef LEIWAND_UART_IRQ_EN
                    UART_REG_IE:     if (bus.wen[0]) ie <= bus.wdata[1:0];
`endif
                    default: ;
                endcase
            end
`ifdef LEIWAND_UART_IRQ_EN
            irq <= |(ie & ip);
`endif
        end
    end

    assign tx_tick = (tx_baud == 16'd0);

    always_comb begin
        tx_state_d = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE:  if (txen && !tx_empty) begin
                          tx_pop     = 1'b1;
                          tx_state_d = ST_START;
                      end
            ST_START: if (tx_tick) tx_state_d = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_d = ST_STOP;
            ST_STOP:  if (tx_tick) tx_state_d = ST_IDLE;
            default:  tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_baud  <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            if (tx_state == ST_IDLE) begin
                tx_baud <= div;
                tx_bit  <= 3'd0;
                if (tx_pop) begin
                    tx_shift <= tx_dout;
                    uart_tx  <= 1'b0;
                end
            end else if (tx_tick) begin
                tx_baud <= div;
                case (tx_state)
                    ST_START: uart_tx <= tx_shift[0];
                    ST_DATA: begin
                        if (tx_bit == 3'd7) begin
                            uart_tx <= 1'b1;
                        end else begin
                            uart_tx  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    default: uart_tx <= 1'b1;
                endcase
            end else begin
                tx_baud <= tx_baud - 16'd1;
            end
        end
    end

    assign rx_tick = (rx_baud == 16'd0);
    assign rx_fall = rx_s3 && !rx_s2;

    always_comb begin
        rx_state_d = rx_state;
        rx_push    = 1'b0;
        case (rx_state)
            ST_IDLE:  if (rxen && rx_fall) rx_state_d = ST_START;
            ST_START: if (rx_tick) rx_state_d = rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_d = ST_STOP;
            ST_STOP:  if (rx_tick) begin
                          rx_state_d = ST_IDLE;
                          rx_push    = rx_s2;
                      end
            default:  rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_baud  <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_d;
            // Idle keeps the half-bit count loaded so START samples mid-bit.
            if (rx_state == ST_IDLE) begin
                rx_baud <= div_inc[16:1];
                rx_bit  <= 3'd0;
            end else if (rx_tick) begin
                rx_baud <= div;
                if (rx_state == ST_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end else begin
                rx_baud <= rx_baud - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_uart.sv
module tb_leiwand_rv32_uart;
    import leiwand_rv32_uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_tx;
    logic uart_rx;
`ifdef LEIWAND_UART_IRQ_EN
    logic irq;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cur_div  = 433;

    logic [7:0] tx_seen[$];
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];

    always #5 clk = ~clk;

    leiwand_rv32_uart_if bus ();

    leiwand_rv32_uart dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (bus),
`ifdef LEIWAND_UART_IRQ_EN
        .irq     (irq),
`endif
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_access(input logic [2:0] off, input logic [3:0] wen,
                              input logic [31:0] wdata, output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = UART_BASE_ADDR + {27'b0, off, 2'b00};
        bus.wen   = wen;
        bus.wdata = wdata;
        got   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.ready) begin
                got   = 1'b1;
                rdata = bus.rdata;
            end
        end
        bus.valid = 1'b0;
        bus.wen   = 4'b0;
        if (!got) chk("bus_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [3:0] wen, input logic [31:0] d);
        logic [31:0] dummy;
        bus_access(off, wen, d, dummy);
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [31:0] d);
        bus_access(off, 4'b0, 32'b0, d);
    endtask

    // Drive one 8N1 frame; model: a good frame lands in the RX queue if room.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (cur_div + 1) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * (cur_div + 1)) @(negedge clk);
        if (stop && rx_model.size() < 8) rx_model.push_back(b);
    endtask

    task automatic rx_expect(input string tag);
        logic [31:0] r, e;
        bus_rd(UART_REG_RXDATA, r);
        if (rx_model.size() == 0) e = 32'h8000_0000;
        else e = {24'b0, rx_model.pop_front()};
        chk(tag, r, e);
    endtask

    // Line monitor: decodes frames by mid-bit sampling at the current divider.
    always begin
        @(posedge clk); #1;
        if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            int p;
            logic [7:0] b;
            logic ok;
            p  = cur_div + 1;
            ok = 1'b1;
            repeat (p / 2) @(posedge clk);
            #1;
            if (uart_tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (p) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            repeat (p) @(posedge clk);
            #1;
            if (ok && uart_tx === 1'b1) tx_seen.push_back(b);
        end
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic [9:0]  frame;
        int bad, nready, lows;

        rst_n = 1'b0;
        bus.valid = 1'b0; bus.wen = 4'b0; bus.addr = 32'b0; bus.wdata = 32'b0;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        bus_rd(UART_REG_TXDATA, r); chk("rst_txdata", r, 32'h0000_0000);
        bus_rd(UART_REG_RXDATA, r); chk("rst_rxdata", r, 32'h8000_0000);
        bus_rd(UART_REG_DIV, r);    chk("rst_div", r, 32'h0000_01B1);

        // Single frame, exact per-clock waveform
        bus_wr(UART_REG_DIV, 4'b0011, 32'h0000_0003);
        cur_div = 3;
        bus_wr(UART_REG_TXCTRL, 4'b0001, 32'h1);
        bus_wr(UART_REG_TXDATA, 4'b0001, 32'h55);
        for (int i = 0; i < 20 && uart_tx !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        frame = {1'b1, 8'h55, 1'b0};
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (uart_tx !== frame[k / 4]) bad++;
            @(posedge clk); #1;
        end
        chk("tx_wave_55", bad, 0);
        chk("tx_idle_after", {31'b0, uart_tx}, 32'd1);
        chk("tx_mon_count", tx_seen.size(), 1);
        if (tx_seen.size() > 0) chk("tx_mon_55", {24'b0, tx_seen[0]}, 32'h55);

        // TX FIFO fill beyond depth with transmitter off
        tx_seen.delete();
        bus_wr(UART_REG_TXCTRL, 4'b0001, 32'h0);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            bus_wr(UART_REG_TXDATA, 4'b0001, {$urandom, b} >> 0 & 32'hFF | 32'h0);
            if (tx_model.size() < 8) tx_model.push_back(b);
        end
        bus_rd(UART_REG_TXDATA, r);
        chk("tx_full_flag", r, (tx_model.size() == 8) ? 32'h8000_0000 : 32'h0);
        bus_wr(UART_REG_TXCTRL, 4'b0001, 32'h1);
        repeat (8 * 41 + 60) @(posedge clk);
        #1;
        chk("tx_burst_count", tx_seen.size(), tx_model.size());
        for (int i = 0; i < 8; i++) begin
            if (i < tx_seen.size() && i < tx_model.size())
                chk($sformatf("tx_burst_%0d", i), {24'b0, tx_seen[i]}, {24'b0, tx_model[i]});
        end
        bus_rd(UART_REG_TXDATA, r); chk("tx_drained", r, 32'h0);

        // Divider byte enables, then receive
        bus_wr(UART_REG_DIV, 4'b0001, 32'hAAAA_BB07);
        cur_div = 7;
        bus_rd(UART_REG_DIV, r); chk("div_byte_wen", r, 32'h0000_0007);
        bus_wr(UART_REG_RXCTRL, 4'b0001, 32'h1);
        rx_frame(8'hA3, 1'b1);
        rx_expect("rx_a3");
        rx_expect("rx_empty_after");

        rx_frame(8'($urandom), 1'b0);
        rx_expect("rx_framing_err");

        for (int i = 0; i < 9; i++) rx_frame(8'($urandom), 1'b1);
        for (int i = 0; i < 9; i++) rx_expect($sformatf("rx_overrun_%0d", i));

        // Valid held for five cycles: one completion, one pop
        rx_frame(8'($urandom), 1'b1);
        rx_frame(8'($urandom), 1'b1);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.addr  = UART_BASE_ADDR + 32'h4;
        bus.wen   = 4'b0;
        nready = 0;
        r = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.ready) begin
                nready++;
                r = bus.rdata;
            end
        end
        bus.valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_ready_pulses", nready, 1);
        chk("hold_rdata", r, (rx_model.size() > 0) ? {24'b0, rx_model.pop_front()} : 32'h8000_0000);
        rx_expect("hold_second_pop");
        rx_expect("hold_then_empty");

`ifdef LEIWAND_UART_IRQ_EN
        bus_wr(UART_REG_IE, 4'b0001, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_txwm", {31'b0, irq}, 32'd1);
        bus_wr(UART_REG_IE, 4'b0001, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_rxwm_empty", {31'b0, irq}, 32'd0);
`endif

        // Reset in the middle of a transmit frame
        rx_frame(8'($urandom), 1'b1);
        bus_wr(UART_REG_DIV, 4'b0011, 32'h3);
        cur_div = 3;
        bus_wr(UART_REG_TXDATA, 4'b0001, 32'hF0);
        bus_wr(UART_REG_TXDATA, 4'b0001, 32'h0F);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'b0, uart_tx}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cur_div = 433;
        rx_model.delete();
        @(posedge clk); #1;
        bus_rd(UART_REG_RXDATA, r); chk("rst_rx_empty", r, 32'h8000_0000);
        bus_rd(UART_REG_TXCTRL, r); chk("rst_txen", r, 32'h0);
        bus_rd(UART_REG_DIV, r);    chk("rst_div_again", r, 32'h0000_01B1);
        bus_wr(UART_REG_TXCTRL, 4'b0001, 32'h1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        chk("rst_tx_fifo_empty", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
